// File: rtl/lcd_pkg.sv
// Shared constants for the ST7789 sequencer: init-table entry types, window
// command codes and the power-up command ROM.
package lcd_pkg;

    typedef enum logic [1:0] {
        EntCmd   = 2'b00,
        EntData  = 2'b01,
        EntDelay = 2'b10,
        EntEnd   = 2'b11
    } entry_type_e;

    localparam logic [7:0] CmdCaset = 8'h2A;
    localparam logic [7:0] CmdRaset = 8'h2B;
    localparam logic [7:0] CmdRamwr = 8'h2C;

    localparam int unsigned InitRomLen = 11;
    localparam int unsigned RomAw      = 4;

    // Entry format {type[1:0], val[7:0]}; delay values are in DELAY_UNIT steps.
    function automatic logic [9:0] init_rom(input logic [RomAw-1:0] idx);
        logic [9:0] ent;
        case (idx)
            4'd0:    ent = {EntCmd,   8'h01};
            4'd1:    ent = {EntDelay, 8'd150};
            4'd2:    ent = {EntCmd,   8'h11};
            4'd3:    ent = {EntDelay, 8'd120};
            4'd4:    ent = {EntCmd,   8'h36};
            4'd5:    ent = {EntData,  8'h70};
            4'd6:    ent = {EntCmd,   8'h3A};
            4'd7:    ent = {EntData,  8'h05};
            4'd8:    ent = {EntCmd,   8'h21};
            4'd9:    ent = {EntCmd,   8'h29};
            default: ent = {EntEnd,   8'h00};
        endcase
        return ent;
    endfunction

endpackage

// File: rtl/lcd_spi_byte_tx.sv
// SPI mode-0 byte shifter: frames one byte with cs low, MSB first, and pulses
// done in the single cs-high cycle that follows the eighth SCK high phase.
module lcd_spi_byte_tx #(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       go_i,
    input  logic       rs_i,
    input  logic [7:0] byte_i,
    output logic       ready_o,
    output logic       done_o,
    output logic       sck_o,
    output logic       cs_o,
    output logic       rs_o,
    output logic       mosi_o
);
    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {TxIdle, TxShift, TxDone} tx_state_e;

    tx_state_e      state_q, state_d;
    logic [DivW-1:0] div_q;
    logic [2:0]     bit_q;
    logic [7:0]     shift_q;
    logic           sck_q, cs_q, rs_q, mosi_q;
    logic           half_end;

    assign half_end = (div_q == DivW'(CLK_DIV - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= TxIdle;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TxIdle:  if (go_i) state_d = TxShift;
            TxShift: if (half_end && sck_q && bit_q == 3'd7) state_d = TxDone;
            TxDone:  state_d = TxIdle;
            default: state_d = TxIdle;
        endcase
    end

    always_comb begin
        ready_o = (state_q == TxIdle);
        done_o  = (state_q == TxDone);
        sck_o   = sck_q;
        cs_o    = cs_q;
        rs_o    = rs_q;
        mosi_o  = mosi_q;
    end

    // rs and mosi are only reloaded on go, so both hold through the cs-low window.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            sck_q   <= 1'b0;
            cs_q    <= 1'b1;
            rs_q    <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            unique case (state_q)
                TxIdle: begin
                    if (go_i) begin
                        shift_q <= byte_i;
                        rs_q    <= rs_i;
                        mosi_q  <= byte_i[7];
                        cs_q    <= 1'b0;
                        sck_q   <= 1'b0;
                        div_q   <= '0;
                        bit_q   <= '0;
                    end
                end
                TxShift: begin
                    if (!half_end) begin
                        div_q <= div_q + 1'b1;
                    end else begin
                        div_q <= '0;
                        if (!sck_q) begin
                            sck_q <= 1'b1;
                        end else begin
                            sck_q <= 1'b0;
                            if (bit_q == 3'd7) begin
                                cs_q <= 1'b1;
                            end else begin
                                bit_q   <= bit_q + 3'd1;
                                shift_q <= {shift_q[6:0], 1'b0};
                                mosi_q  <= shift_q[6];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/lcd_seq_ctrl.sv
// ST7789 sequencer: panel reset pulse, power-up table, then on start a window
// set followed by one frame of RGB565 pixels pulled over valid/ready.
module lcd_seq_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 1,
    parameter int unsigned RST_LOW_CYC  = 100,
    parameter int unsigned RST_WAIT_CYC = 1000,
    parameter int unsigned DELAY_UNIT   = 1000,
    parameter int unsigned LCD_W        = 240,
    parameter int unsigned LCD_H        = 135,
    parameter int unsigned X_OFS        = 40,
    parameter int unsigned Y_OFS        = 53
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [15:0] pix_data_i,
    input  logic        pix_valid_i,
    output logic        pix_ready_o,
    output logic        busy_o,
    output logic        init_done_o,
    output logic        frame_done_o,
    output logic        lcd_resetn_o,
    output logic        lcd_clk_o,
    output logic        lcd_cs_o,
    output logic        lcd_rs_o,
    output logic        lcd_data_o
);
    localparam int unsigned PixTotal = LCD_W * LCD_H;
    localparam logic [15:0] XStart = 16'(X_OFS);
    localparam logic [15:0] XEnd   = 16'(X_OFS + LCD_W - 1);
    localparam logic [15:0] YStart = 16'(Y_OFS);
    localparam logic [15:0] YEnd   = 16'(Y_OFS + LCD_H - 1);

    typedef enum logic [3:0] {
        StRstLow, StRstWait, StInitFetch, StInitSend, StInitDelay,
        StIdle, StWinSend, StPixHi, StPixLo
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [RomAw-1:0] rom_ptr_q, rom_ptr_d;
    logic [3:0]       win_idx_q, win_idx_d;
    logic [16:0]      pix_cnt_q, pix_cnt_d;
    logic [7:0]       pix_lo_q, pix_lo_d;
    logic             sent_q, sent_d;
    logic             init_done_q, init_done_d;
    logic             frame_done_q, frame_done_d;

    logic [9:0]  rom_entry;
    entry_type_e ent_type;
    logic [7:0]  ent_val;
    logic        win_rs;
    logic [7:0]  win_byte;
    logic        tx_go, tx_rs, tx_ready, tx_done;
    logic [7:0]  tx_byte;

    assign rom_entry = init_rom(rom_ptr_q);
    assign ent_type  = entry_type_e'(rom_entry[9:8]);
    assign ent_val   = rom_entry[7:0];

    always_comb begin
        win_rs   = 1'b1;
        win_byte = 8'h00;
        unique case (win_idx_q)
            4'd0:    begin win_rs = 1'b0; win_byte = CmdCaset; end
            4'd1:    win_byte = XStart[15:8];
            4'd2:    win_byte = XStart[7:0];
            4'd3:    win_byte = XEnd[15:8];
            4'd4:    win_byte = XEnd[7:0];
            4'd5:    begin win_rs = 1'b0; win_byte = CmdRaset; end
            4'd6:    win_byte = YStart[15:8];
            4'd7:    win_byte = YStart[7:0];
            4'd8:    win_byte = YEnd[15:8];
            4'd9:    win_byte = YEnd[7:0];
            4'd10:   begin win_rs = 1'b0; win_byte = CmdRamwr; end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StRstLow;
            cnt_q        <= '0;
            rom_ptr_q    <= '0;
            win_idx_q    <= '0;
            pix_cnt_q    <= '0;
            pix_lo_q     <= '0;
            sent_q       <= 1'b0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rom_ptr_q    <= rom_ptr_d;
            win_idx_q    <= win_idx_d;
            pix_cnt_q    <= pix_cnt_d;
            pix_lo_q     <= pix_lo_d;
            sent_q       <= sent_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rom_ptr_d    = rom_ptr_q;
        win_idx_d    = win_idx_q;
        pix_cnt_d    = pix_cnt_q;
        pix_lo_d     = pix_lo_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        // sent_q marks a byte handed to the engine and not yet completed.
        sent_d       = tx_done ? 1'b0 : (tx_go ? 1'b1 : sent_q);
        unique case (state_q)
            StRstLow: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == 32'(RST_LOW_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = StRstWait;
                end
            end
            StRstWait: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == 32'(RST_WAIT_CYC - 1)) begin
                    cnt_d     = '0;
                    rom_ptr_d = '0;
                    state_d   = StInitFetch;
                end
            end
            StInitFetch: begin
                unique case (ent_type)
                    EntCmd, EntData: state_d = StInitSend;
                    EntDelay: begin
                        if (ent_val == 8'd0) begin
                            rom_ptr_d = rom_ptr_q + 1'b1;
                        end else begin
                            cnt_d   = '0;
                            state_d = StInitDelay;
                        end
                    end
                    EntEnd: begin
                        init_done_d = 1'b1;
                        state_d     = StIdle;
                    end
                    default: ;
                endcase
            end
            StInitSend: begin
                if (tx_done) begin
                    rom_ptr_d = rom_ptr_q + 1'b1;
                    state_d   = StInitFetch;
                end
            end
            StInitDelay: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == (32'(ent_val) * DELAY_UNIT) - 32'd1) begin
                    rom_ptr_d = rom_ptr_q + 1'b1;
                    state_d   = StInitFetch;
                end
            end
            StIdle: begin
                if (start_i) begin
                    win_idx_d = '0;
                    state_d   = StWinSend;
                end
            end
            StWinSend: begin
                if (tx_done) begin
                    if (win_idx_q == 4'd10) begin
                        pix_cnt_d = '0;
                        state_d   = StPixHi;
                    end else begin
                        win_idx_d = win_idx_q + 4'd1;
                    end
                end
            end
            StPixHi: begin
                if (tx_go)   pix_lo_d = pix_data_i[7:0];
                if (tx_done) state_d = StPixLo;
            end
            StPixLo: begin
                if (tx_done) begin
                    if (pix_cnt_q == 17'(PixTotal - 1)) begin
                        frame_done_d = 1'b1;
                        state_d      = StIdle;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 17'd1;
                        state_d   = StPixHi;
                    end
                end
            end
            default: state_d = StRstLow;
        endcase
    end

    always_comb begin
        tx_go       = 1'b0;
        tx_rs       = 1'b1;
        tx_byte     = 8'h00;
        pix_ready_o = 1'b0;
        unique case (state_q)
            StInitSend: begin
                tx_go   = tx_ready && !sent_q;
                tx_rs   = (ent_type == EntData);
                tx_byte = ent_val;
            end
            StWinSend: begin
                tx_go   = tx_ready && !sent_q;
                tx_rs   = win_rs;
                tx_byte = win_byte;
            end
            StPixHi: begin
                pix_ready_o = tx_ready && !sent_q;
                tx_go       = pix_ready_o && pix_valid_i;
                tx_byte     = pix_data_i[15:8];
            end
            StPixLo: begin
                tx_go   = tx_ready && !sent_q;
                tx_byte = pix_lo_q;
            end
            default: ;
        endcase
        busy_o       = (state_q != StIdle);
        lcd_resetn_o = (state_q != StRstLow);
        init_done_o  = init_done_q;
        frame_done_o = frame_done_q;
    end

    lcd_spi_byte_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_byte_tx (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .go_i    (tx_go),
        .rs_i    (tx_rs),
        .byte_i  (tx_byte),
        .ready_o (tx_ready),
        .done_o  (tx_done),
        .sck_o   (lcd_clk_o),
        .cs_o    (lcd_cs_o),
        .rs_o    (lcd_rs_o),
        .mosi_o  (lcd_data_o)
    );

endmodule

// File: doc/lcd_seq_ctrl.md
# lcd_seq_ctrl

Sequencer for the 1.14" ST7789 SPI LCD (240×135, RGB565). After reset it drives the panel hardware-reset pulse and plays the power-up command table. It then sits idle until a `start` pulse. On `start` it sets the full-screen window and streams one frame of pixels, pulled from an upstream requester through a valid/ready handshake. It sits between the pixel source (pattern generator / frame logic) and the `lcd_*` pins of the top-level LCD test design.

## Interface
- `CLK_DIV`, 1: `clk` cycles per SPI half-period (≥1)
- `RST_LOW_CYC`, 100: cycles `lcd_resetn` is held low after reset
- `RST_WAIT_CYC`, 1000: cycles waited after `lcd_resetn` rises, before the first command
- `DELAY_UNIT`, 1000: `clk` cycles per delay-entry count
- `LCD_W`, 240 / `LCD_H`, 135: panel size
- `X_OFS`, 40 / `Y_OFS`, 53: controller RAM offsets applied to the window
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to send one frame; honoured only in IDLE
- `pix_data`  in  16  RGB565 pixel
- `pix_valid`  in  1  `pix_data` valid
- `pix_ready`  out  1  controller will accept a pixel this cycle
- `busy`  out  1  high in every state except IDLE
- `init_done`  out  1  high once the init table has finished; stays high until reset
- `frame_done`  out  1  one-cycle pulse after the last pixel byte has completed
- `lcd_resetn`  out  1  panel reset, active low
- `lcd_clk`  out  1  SPI SCK, mode 0 (idle low)
- `lcd_cs`  out  1  chip select, active low
- `lcd_rs`  out  1  0 = command, 1 = data
- `lcd_data`  out  1  MOSI, MSB first

## Operation
- States: RST_LOW → RST_WAIT → INIT_FETCH → {INIT_SEND | INIT_DELAY} → … → IDLE → WIN_SEND → PIX_HI → PIX_LO → … → IDLE.
- **Init table:** a ROM of 10-bit entries {type[1:0], val[7:0]}.
  - Types: 00 = command byte (rs=0), 01 = data byte (rs=1), 10 = delay of val×`DELAY_UNIT` cycles, 11 = end.
  - On reaching the end entry: set `init_done`, go to IDLE.
  - A delay with val=0 lasts 0 cycles; go straight to the next fetch.
- **Window set (WIN_SEND):** 11 bytes, in this order:
  - 0x2A (command), then 4 data bytes: X_OFS, X_OFS+LCD_W-1, each as 16-bit big-endian.
  - 0x2B (command), then 4 data bytes: Y_OFS, Y_OFS+LCD_H-1, each as 16-bit big-endian.
  - 0x2C (command).
- **Pixel stream:**
  - In PIX_HI with the byte engine idle, `pix_ready`=1.
  - On `pix_valid&pix_ready`: latch the pixel and send the high byte, then the low byte (both rs=1).
  - A 17-bit counter runs up to LCD_W×LCD_H = 32400.
  - If `pix_valid` is low, the bus stalls with cs high; no timeout.
- After the final low byte: pulse `frame_done`, return to IDLE.
- `start` outside IDLE is dropped, not queued.
- `start` asserted together with `reset`: `reset` wins.
- **Reset mid-operation:** the whole sequence restarts from RST_LOW, including the panel reset pulse and the init table.

## Timing
- Reset values: `lcd_resetn`=0, `lcd_cs`=1, `lcd_clk`=0, `lcd_rs`=0, `lcd_data`=0, `pix_ready`=0, `busy`=1, `init_done`=0, `frame_done`=0.
- `lcd_resetn` is low for exactly RST_LOW_CYC cycles after `reset` deasserts.
- The first cs fall comes ≥RST_WAIT_CYC cycles after `lcd_resetn` rises.
- **Byte transaction** (`go` accepted at cycle 0):
  - Cycle 1: cs=0, rs valid, bit 7 on `lcd_data`.
  - Each bit: `lcd_clk` is low for CLK_DIV cycles, then high for CLK_DIV cycles. Data changes only while SCK is low.
  - After the 8th high phase: cs=1 for one cycle, and the engine pulses `done`.
  - Next `go` no earlier than the cycle after `done`. Byte period = 16·CLK_DIV+2 cycles.
- `rs` is stable for the entire cs-low window.
- `pix_ready` deasserts the cycle after the accepting handshake.
- `frame_done` is high in the same cycle that `busy` falls.

## Structure
- Package `lcd_pkg`:
  - Entry-type constants.
  - Command codes 0x2A/0x2B/0x2C.
  - Init ROM contents: 0x01, delay 150; 0x11, delay 120; 0x36/0x70; 0x3A/0x05; 0x21; 0x29; end.
  - Init ROM length.
- Sub-module `lcd_spi_byte_tx`:
  - Inputs: clk, reset, go, rs, byte.
  - Outputs: done, sck, cs, rs, mosi.
  - Holds the CLK_DIV divider and the bit counter.
- Top FSM: state, ROM pointer, delay counter, window-byte index, pixel counter.

## Test plan
- Reset → `lcd_resetn` low for 100 cycles. First cs-low byte is 0x01, rs=0, captured on SCK rising edges. `init_done` rises after the 0x29 byte.
- Init with `DELAY_UNIT`=10 → gap between the end of 0x01 and the start of 0x11 is ≥1500 cycles.
- `start` in IDLE → bytes 2A 00 28 01 17 2B 00 35 00 BB 2C. rs is 0 on 2A/2B/2C and 1 on the rest.
- Pixel source sends 0xF81F with `pix_valid` tied high → byte stream F8 1F repeated. Exactly 32400 pixels are accepted, then one `frame_done` pulse.
- `pix_valid` dropped for 50 cycles mid-frame → cs stays high and no SCK edges occur. The stream resumes with the next pixel; no pixel is lost or duplicated.
- `reset` asserted mid-frame (pixel 1000), plus `start` asserted while busy → all outputs return to reset values the next cycle, and the init replays. The busy-time `start` produces no window bytes.
